stream_out_port: RTL
====================

STREAM_OUT_PORT -- requirements
Module: stream_out_port

Interface
REQ-001 SHALL have parameter DSIZE, default 24, the pixel data width in bits.
REQ-002 SHALL have port aclk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port aresetn  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port enable  input  1  allows new frames to start; sampled only in IDLE.
REQ-005 SHALL have port vactive  input  16  lines per frame; sampled at frame start.
REQ-006 SHALL have port hactive  input  16  pixels per line; sampled at frame start.
REQ-007 SHALL have port fsync  input  1  frame start trigger, used only when STREAM_OUT_FSYNC_EN is defined.
REQ-008 SHALL have port fifo_empty  input  1  read-side FIFO empty flag (first-word-fall-through).
REQ-009 SHALL have port fifo_rdata  input  DSIZE  FIFO head word, valid while fifo_empty is low.
REQ-010 SHALL have port fifo_rd_en  output  1  pops one FIFO word in the cycle it is high.
REQ-011 SHALL have port axi_tdata  output  DSIZE  AXI4-Stream master data.
REQ-012 SHALL have port axi_tvalid  output  1  AXI4-Stream master valid.
REQ-013 SHALL have port axi_tready  input  1  AXI4-Stream slave ready.
REQ-014 SHALL have port axi_tuser  output  1  start of frame, high on the first beat of each frame only.
REQ-015 SHALL have port axi_tlast  output  1  end of line, high on the last beat of each line.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse after the last beat of a frame is accepted.

Function
REQ-017 SHALL implement states IDLE, ARM, STREAM and DRAIN.
REQ-018 SHALL latch vactive and hactive into internal registers on leaving IDLE, and SHALL ignore later changes until the next frame.
REQ-019 SHALL stay in IDLE when enable=0, vactive=0 or hactive=0.
REQ-020 SHALL drive fifo_rd_en = (state==STREAM) & ~fifo_empty & (~axi_tvalid | axi_tready) combinationally.
REQ-021 SHALL, in the cycle fifo_rd_en=1, register fifo_rdata into axi_tdata and set axi_tvalid=1 at the next edge (one-cycle latency).
REQ-022 SHALL keep axi_tdata, axi_tuser and axi_tlast stable while axi_tvalid=1 and axi_tready=0.
REQ-023 SHALL clear axi_tvalid after a handshake (valid & ready) when no new word loads in the same cycle.
REQ-024 SHALL sustain one beat per cycle when the FIFO is non-empty and axi_tready stays high.
REQ-025 SHALL count issued beats with hcnt (0..hactive-1) and lines with vcnt (0..vactive-1), both 16-bit, advancing on fifo_rd_en.
REQ-026 SHALL set axi_tuser on the beat loaded with hcnt=0 and vcnt=0, and SHALL clear it on all other beats.
REQ-027 SHALL set axi_tlast on the beat loaded with hcnt=hactive-1, wrap hcnt to 0 and increment vcnt.
REQ-028 SHALL move from STREAM to DRAIN when it loads the beat with hcnt=hactive-1 and vcnt=vactive-1, and SHALL stop popping the FIFO.
REQ-029 SHALL move from DRAIN to IDLE on that final beat's handshake, and SHALL pulse frame_done on the following cycle.
REQ-030 SHALL insert no bubble and no data when the FIFO underruns mid-frame: axi_tvalid drops and the counters hold.
REQ-031 SHALL ignore fsync in STREAM and DRAIN.

Reset
REQ-032 SHALL, on aresetn=0 at a rising edge, set state=IDLE, hcnt=vcnt=0 and axi_tvalid, axi_tuser, axi_tlast, frame_done, axi_tdata=0, including when reset arrives mid-frame.
REQ-033 SHALL hold fifo_rd_en=0 while aresetn=0.

Configuration
REQ-034 SHALL, with STREAM_OUT_FSYNC_EN defined, go from IDLE (enable=1, sizes nonzero) to ARM, and from ARM to STREAM on the first cycle fsync=1; enable=0 in ARM returns to IDLE.
REQ-035 SHALL, without STREAM_OUT_FSYNC_EN, go from IDLE directly to STREAM, never enter ARM, and leave fsync unused.

Verification
REQ-036 SHALL cover: hactive=4, vactive=2, FIFO preloaded with 8 words, tready=1 -> 8 consecutive beats; tuser on beat 0; tlast on beats 3 and 7; frame_done one cycle after beat 7.
REQ-037 SHALL cover: the same frame with tready toggled 1,0,0,1 -> no beat lost or duplicated, and tdata/tuser/tlast stable during stalls.
REQ-038 SHALL cover: FIFO empty for 5 cycles after beat 2 -> tvalid low for those cycles, resumes with beat 3 and correct tlast position.
REQ-039 SHALL cover: aresetn=0 for one cycle after beat 5 -> all outputs 0, state IDLE; the next frame starts with tuser=1.
REQ-040 SHALL cover: with STREAM_OUT_FSYNC_EN defined, enable=1 and fsync low for 10 cycles -> no fifo_rd_en; fsync pulse -> first beat valid 2 cycles later.
REQ-041 SHALL cover: vactive=0 with enable=1 -> no FIFO pop and no tvalid for 20 cycles.

Source files
------------

// File: rtl/stream_out_port_if.sv
// stream_out_port_if: AXI4-Stream video beat bundle.
// master drives data/valid/user/last, slave drives ready.
interface stream_out_port_if #(
   parameter int DSIZE = 24
);
   logic [DSIZE-1:0] axi_tdata;
   logic             axi_tvalid;
   logic             axi_tready;
   logic             axi_tuser;
   logic             axi_tlast;

   modport master (
      output axi_tdata,
      output axi_tvalid,
      output axi_tuser,
      output axi_tlast,
      input  axi_tready
   );

   modport slave (
      input  axi_tdata,
      input  axi_tvalid,
      input  axi_tuser,
      input  axi_tlast,
      output axi_tready
   );
endinterface

// File: rtl/stream_out_port.sv
// stream_out_port: FWFT FIFO to AXI4-Stream video master with frame sizing.
// Define STREAM_OUT_FSYNC_EN to hold each frame in ARM until fsync.
module stream_out_port #(
   parameter int DSIZE = 24
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              enable,
   input  logic [15:0]       vactive,
   input  logic [15:0]       hactive,
   input  logic              fsync,
   input  logic              fifo_empty,
   input  logic [DSIZE-1:0]  fifo_rdata,
   output logic              fifo_rd_en,
   stream_out_port_if.master axi,
   output logic              frame_done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM    = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      hact_q, hact_d;
   logic [15:0]      vact_q, vact_d;
   logic [15:0]      hcnt_q, hcnt_d;
   logic [15:0]      vcnt_q, vcnt_d;
   logic [DSIZE-1:0] tdata_q, tdata_d;
   logic             tvalid_q, tvalid_d;
   logic             tuser_q, tuser_d;
   logic             tlast_q, tlast_d;
   logic             done_q, done_d;

   logic start;
   logic hs;
   logic h_end;
   logic v_end;

   assign start = enable & (|vactive) & (|hactive);
   assign hs    = tvalid_q & axi.axi_tready;
   assign h_end = (hcnt_q == hact_q - 16'd1);
   assign v_end = (vcnt_q == vact_q - 16'd1);

`ifndef STREAM_OUT_FSYNC_EN
   logic unused_fsync;
   assign unused_fsync = fsync;
`endif

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
`ifdef STREAM_OUT_FSYNC_EN
               state_d = ARM;
`else
               state_d = STREAM;
`endif
            end
         end
         ARM: begin
`ifdef STREAM_OUT_FSYNC_EN
            if (!enable) begin
               state_d = IDLE;
            end else if (fsync) begin
               state_d = STREAM;
            end
`else
            state_d = IDLE;
`endif
         end
         STREAM: begin
            if (fifo_rd_en && h_end && v_end) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (hs) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pop only when the output register is free or being emptied this cycle.
   always_comb begin
      fifo_rd_en = 1'b0;
      if (aresetn && state_q == STREAM) begin
         fifo_rd_en = ~fifo_empty & (~tvalid_q | axi.axi_tready);
      end
      axi.axi_tdata  = tdata_q;
      axi.axi_tvalid = tvalid_q;
      axi.axi_tuser  = tuser_q;
      axi.axi_tlast  = tlast_q;
      frame_done     = done_q;
   end

   always_comb begin
      hact_d   = hact_q;
      vact_d   = vact_q;
      hcnt_d   = hcnt_q;
      vcnt_d   = vcnt_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tuser_d  = tuser_q;
      tlast_d  = tlast_q;
      done_d   = (state_q == DRAIN) & hs;
      if (state_q == IDLE && start) begin
         hact_d = hactive;
         vact_d = vactive;
         hcnt_d = '0;
         vcnt_d = '0;
      end
      if (fifo_rd_en) begin
         tdata_d  = fifo_rdata;
         tvalid_d = 1'b1;
         tuser_d  = (hcnt_q == 16'd0) && (vcnt_q == 16'd0);
         tlast_d  = h_end;
         if (h_end) begin
            hcnt_d = '0;
            vcnt_d = v_end ? 16'd0 : vcnt_q + 16'd1;
         end else begin
            hcnt_d = hcnt_q + 16'd1;
         end
      end else if (hs) begin
         tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         hact_q   <= '0;
         vact_q   <= '0;
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tuser_q  <= 1'b0;
         tlast_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         hact_q   <= hact_d;
         vact_q   <= vact_d;
         hcnt_q   <= hcnt_d;
         vcnt_q   <= vcnt_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tuser_q  <= tuser_d;
         tlast_q  <= tlast_d;
         done_q   <= done_d;
      end
   end

endmodule
